// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: row scanner, press/release debouncer and key-event
// generator for a 4x4 matrix keypad.
//
// One scheduler owns the whole sequence: it strobes rows one-hot, samples the
// (already synchronized) columns at the end of each row dwell, debounces a
// single captured key, and emits one single-cycle key_valid per press.
//
// Optional build feature, macro KEYPAD_AUTOREPEAT_EN:
//   - When defined, a held key re-emits key_valid after REPEAT_DELAY cycles,
//     then every REPEAT_PERIOD cycles.
//   - When undefined, the repeat logic is absent and the REPEAT_* parameters
//     are ignored.
module keypad_scan_ctrl #(
   parameter int SCAN_DIV      = 6000,
   parameter int DB_CYCLES     = 60000,
   parameter int REPEAT_DELAY  = 3000000,
   parameter int REPEAT_PERIOD = 600000
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [3:0] col_i,
   output logic [3:0] row_o,
   output logic       key_valid,
   output logic [3:0] key_row,
   output logic [3:0] key_col,
   output logic       busy,
   output logic [2:0] dbg_state
);

   typedef enum logic [2:0] {
      ST_SCAN        = 3'd0,
      ST_DEB_PRESS   = 3'd1,
      ST_HELD        = 3'd2,
      ST_DEB_RELEASE = 3'd3
   } state_t;

   // Dwell counter runs 0..SCAN_DIV-1.
   localparam int              DW_W       = $clog2(SCAN_DIV);
   localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(SCAN_DIV - 1);
   localparam logic [DW_W-1:0] DW_INC     = DW_W'(1);

   // The cycle that enters DEB_PRESS / DEB_RELEASE already counts as the
   // first stable cycle, so the counter only has to reach DB_CYCLES-2 before
   // the terminal transition. DB_CYCLES==1 bypasses the debounce states.
   localparam int              DB_W    = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);
   localparam logic [DB_W-1:0] DB_LAST = (DB_CYCLES < 2) ? {DB_W{1'b0}} : DB_W'(DB_CYCLES - 2);
   localparam logic [DB_W-1:0] DB_INC  = DB_W'(1);
   localparam logic            DB_ONE  = (DB_CYCLES == 1) ? 1'b1 : 1'b0;

   // True when exactly one column bit is set.
   function automatic logic is_onehot4(input logic [3:0] v);
      is_onehot4 = (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
   endfunction

   // Rotate a one-hot row strobe left, wrapping 1000 back to 0001.
   function automatic logic [3:0] rotl4(input logic [3:0] v);
      rotl4 = {v[2:0], v[3]};
   endfunction

   state_t            state_r, state_n;
   logic [DW_W-1:0]   dwell_r, dwell_n;
   logic [DB_W-1:0]   db_r, db_n;
   logic [3:0]        row_r, row_n;
   logic [3:0]        cap_row_r, cap_row_n;
   logic [3:0]        cap_col_r, cap_col_n;
   logic              key_valid_r, key_valid_n;
   logic [3:0]        key_row_r, key_row_n;
   logic [3:0]        key_col_r, key_col_n;
   logic              busy_r;
   logic [2:0]        dbg_state_r;
   logic              cap_present_s;

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int              REP_MAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int              REP_W      = (REP_MAX < 2) ? 1 : $clog2(REP_MAX);
   localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
   localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);
   localparam logic [REP_W-1:0] REP_INC         = REP_W'(1);

   logic [REP_W-1:0]  rep_r, rep_n;
   logic              first_done_r, first_done_n;
`else
   logic              unused_repeat_cfg_s;
   assign unused_repeat_cfg_s = (REPEAT_DELAY != 0) ^ (REPEAT_PERIOD != 0);
`endif

   assign cap_present_s = ((col_i & cap_col_r) != 4'b0000);

   // Next-state, counter and output-intent logic for the scan/debounce scheduler.
   always_comb begin
      state_n     = state_r;
      dwell_n     = dwell_r;
      db_n        = db_r;
      row_n       = row_r;
      cap_row_n   = cap_row_r;
      cap_col_n   = cap_col_r;
      key_valid_n = 1'b0;
      key_row_n   = key_row_r;
      key_col_n   = key_col_r;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_n        = rep_r;
      first_done_n = first_done_r;
`endif

      case (state_r)
         ST_SCAN: begin
            if (dwell_r == DWELL_LAST) begin
               dwell_n = {DW_W{1'b0}};
               db_n    = {DB_W{1'b0}};
               if (is_onehot4(col_i)) begin
                  // Single key on this row: freeze the row and debounce it.
                  cap_row_n = row_r;
                  cap_col_n = col_i;
                  if (DB_ONE) begin
                     state_n     = ST_HELD;
                     key_valid_n = 1'b1;
                     key_row_n   = row_r;
                     key_col_n   = col_i;
`ifdef KEYPAD_AUTOREPEAT_EN
                     rep_n        = {REP_W{1'b0}};
                     first_done_n = 1'b0;
`endif
                  end else begin
                     state_n = ST_DEB_PRESS;
                  end
               end else begin
                  // Nothing pressed or ambiguous multi-key: move on.
                  row_n = rotl4(row_r);
               end
            end else begin
               dwell_n = dwell_r + DW_INC;
            end
         end

         ST_DEB_PRESS: begin
            if (col_i == cap_col_r) begin
               if (db_r == DB_LAST) begin
                  state_n     = ST_HELD;
                  db_n        = {DB_W{1'b0}};
                  key_valid_n = 1'b1;
                  key_row_n   = cap_row_r;
                  key_col_n   = cap_col_r;
`ifdef KEYPAD_AUTOREPEAT_EN
                  rep_n        = {REP_W{1'b0}};
                  first_done_n = 1'b0;
`endif
               end else begin
                  db_n = db_r + DB_INC;
               end
            end else begin
               // Bounce, early release or an extra key: abandon silently.
               state_n = ST_SCAN;
               row_n   = rotl4(row_r);
               dwell_n = {DW_W{1'b0}};
               db_n    = {DB_W{1'b0}};
            end
         end

         ST_HELD: begin
            if (!cap_present_s) begin
               db_n = {DB_W{1'b0}};
               if (DB_ONE) begin
                  state_n = ST_SCAN;
                  row_n   = rotl4(row_r);
                  dwell_n = {DW_W{1'b0}};
               end else begin
                  state_n = ST_DEB_RELEASE;
               end
            end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
               if (rep_r == (first_done_r ? REP_PERIOD_LAST : REP_DELAY_LAST)) begin
                  key_valid_n  = 1'b1;
                  rep_n        = {REP_W{1'b0}};
                  first_done_n = 1'b1;
               end else begin
                  rep_n = rep_r + REP_INC;
               end
`else
               state_n = ST_HELD;
`endif
            end
         end

         ST_DEB_RELEASE: begin
            if (!cap_present_s) begin
               if (db_r == DB_LAST) begin
                  state_n = ST_SCAN;
                  row_n   = rotl4(row_r);
                  dwell_n = {DW_W{1'b0}};
                  db_n    = {DB_W{1'b0}};
               end else begin
                  db_n = db_r + DB_INC;
               end
            end else begin
               // Key bounced back: still the same press, no new event.
               state_n = ST_HELD;
               db_n    = {DB_W{1'b0}};
            end
         end

         default: begin
            state_n = ST_SCAN;
            row_n   = 4'b0001;
            dwell_n = {DW_W{1'b0}};
            db_n    = {DB_W{1'b0}};
         end
      endcase
   end

   // State, counters, capture registers and registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r     <= ST_SCAN;
         dwell_r     <= {DW_W{1'b0}};
         db_r        <= {DB_W{1'b0}};
         row_r       <= 4'b0001;
         cap_row_r   <= 4'b0000;
         cap_col_r   <= 4'b0000;
         key_valid_r <= 1'b0;
         key_row_r   <= 4'b0000;
         key_col_r   <= 4'b0000;
         busy_r      <= 1'b0;
         dbg_state_r <= 3'd0;
      end else begin
         state_r     <= state_n;
         dwell_r     <= dwell_n;
         db_r        <= db_n;
         row_r       <= row_n;
         cap_row_r   <= cap_row_n;
         cap_col_r   <= cap_col_n;
         key_valid_r <= key_valid_n;
         key_row_r   <= key_row_n;
         key_col_r   <= key_col_n;
         busy_r      <= (state_n != ST_SCAN);
         dbg_state_r <= state_n;
      end
   end

`ifdef KEYPAD_AUTOREPEAT_EN
   // Auto-repeat counter; it only advances in HELD and survives release bounces.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rep_r        <= {REP_W{1'b0}};
         first_done_r <= 1'b0;
      end else begin
         rep_r        <= rep_n;
         first_done_r <= first_done_n;
      end
   end
`endif

   assign row_o     = row_r;
   assign key_valid = key_valid_r;
   assign key_row   = key_row_r;
   assign key_col   = key_col_r;
   assign busy      = busy_r;
   assign dbg_state = dbg_state_r;

endmodule
